lt24_lcd_write_ctrl: RTL and testbench

- Drives the LT24 (ILI9341) 8080-style 16-bit parallel write bus from a valid/ready command/data word stream.
- Sits directly downstream of the SOPC LCD master, in the path to LT24_CS_N/RS/WR_N/RD_N/D/RESET_N.
- Owns the panel hardware-reset sequence and all write-cycle timing, so upstream logic only pushes words.

---
 rtl/lt24_pkg.sv | 28 ++
 rtl/lt24_lcd_write_ctrl.sv | 155 +++++++++++++++
 tb/tb_lt24_lcd_write_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lt24_pkg.sv
// ---------------------------------------------------------------------------
// lt24_pkg
// Shared definitions for the LT24 (ILI9341) 8080-style write controller:
// controller state encoding, default 50 MHz timing and RS pin encoding.
// ---------------------------------------------------------------------------
package lt24_pkg;

    typedef enum logic [2:0] {
        ST_RST_LOW  = 3'd0,
        ST_RST_WAIT = 3'd1,
        ST_IDLE     = 3'd2,
        ST_SETUP    = 3'd3,
        ST_WR_LOW   = 3'd4,
        ST_WR_HIGH  = 3'd5
    } lt24_state_t;

    // Default timing at 50 MHz: 1 ms reset pulse, 120 ms post-reset wait,
    // 40 ns strobe low, 40 ns strobe high.
    localparam int unsigned LT24_RST_LOW_CYCLES  = 50000;
    localparam int unsigned LT24_RST_WAIT_CYCLES = 6000000;
    localparam int unsigned LT24_WR_LOW_CYCLES   = 2;
    localparam int unsigned LT24_WR_HIGH_CYCLES  = 2;

    // Register-select pin encoding.
    localparam logic LT24_RS_CMD  = 1'b0;
    localparam logic LT24_RS_DATA = 1'b1;

endpackage

// File: rtl/lt24_lcd_write_ctrl.sv
// ---------------------------------------------------------------------------
// lt24_lcd_write_ctrl
// Converts a valid/ready stream of command/data words into LT24 8080-style
// 16-bit parallel write cycles, and owns the panel hardware-reset sequence.
//
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   rst_req           one-cycle pulse restarting the panel reset sequence
//   s_valid/s_ready   upstream handshake; s_rs selects command(0)/data(1),
//                     s_data is the 16-bit word
//   init_done         high once the panel reset sequence has completed
//   busy              high whenever the controller is not IDLE
//   lt24_*            panel pins (cs_n, rs, wr_n, rd_n, d, reset_n)
//
// Every panel pin is registered from the next state so the pins never
// glitch. One shared down-counter times all phases; it is loaded with
// (cycles-1) on entry to a state and the state exits when it reads zero.
// ---------------------------------------------------------------------------
module lt24_lcd_write_ctrl
    import lt24_pkg::*;
#(
    parameter int unsigned RST_LOW_CYCLES  = LT24_RST_LOW_CYCLES,
    parameter int unsigned RST_WAIT_CYCLES = LT24_RST_WAIT_CYCLES,
    parameter int unsigned WR_LOW_CYCLES   = LT24_WR_LOW_CYCLES,
    parameter int unsigned WR_HIGH_CYCLES  = LT24_WR_HIGH_CYCLES
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rst_req,
    input  logic        s_valid,
    input  logic        s_rs,
    input  logic [15:0] s_data,
    output logic        s_ready,
    output logic        init_done,
    output logic        busy,
    output logic        lt24_cs_n,
    output logic        lt24_rs,
    output logic        lt24_wr_n,
    output logic        lt24_rd_n,
    output logic [15:0] lt24_d,
    output logic        lt24_reset_n
);

    // Counter wide enough for the longest phase, strobe phases included so
    // an unusual parameter set cannot truncate a write timing load.
    localparam int unsigned CNT_MAX_RST = (RST_WAIT_CYCLES > RST_LOW_CYCLES) ?
                                          RST_WAIT_CYCLES : RST_LOW_CYCLES;
    localparam int unsigned CNT_MAX_WR  = (WR_LOW_CYCLES > WR_HIGH_CYCLES) ?
                                          WR_LOW_CYCLES : WR_HIGH_CYCLES;
    localparam int unsigned CNT_MAX     = (CNT_MAX_RST > CNT_MAX_WR) ?
                                          CNT_MAX_RST : CNT_MAX_WR;
    localparam int          CNT_W       = $clog2(CNT_MAX + 1);

    // Every phase needs at least one clock; a zero would underflow the load.
    if (WR_LOW_CYCLES == 0 || WR_HIGH_CYCLES == 0 ||
        RST_LOW_CYCLES == 0 || RST_WAIT_CYCLES == 0) begin : g_bad_timing
        $error("lt24_lcd_write_ctrl: phase cycle counts must be at least 1");
    end

    lt24_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             handshake;

    logic             reset_n_nxt;
    logic             cs_n_nxt;
    logic             wr_n_nxt;
    logic             rs_nxt;
    logic [15:0]      d_nxt;
    logic             init_done_nxt;

    // Counter value that makes a state last its configured number of clocks.
    function automatic logic [CNT_W-1:0] load_for(input lt24_state_t st);
        case (st)
            ST_RST_LOW:  return CNT_W'(RST_LOW_CYCLES - 1);
            ST_RST_WAIT: return CNT_W'(RST_WAIT_CYCLES - 1);
            ST_WR_LOW:   return CNT_W'(WR_LOW_CYCLES - 1);
            ST_WR_HIGH:  return CNT_W'(WR_HIGH_CYCLES - 1);
            default:     return '0;
        endcase
    endfunction

    // rst_req masks the handshake so a word offered on that clock is dropped.
    assign s_ready   = ((state == ST_IDLE) ||
                        (state == ST_WR_HIGH && cnt == '0)) && !rst_req;
    assign handshake = s_valid && s_ready;
    assign busy      = (state != ST_IDLE);
    assign lt24_rd_n = 1'b1;

    // State, counter and pin registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_RST_LOW;
            cnt          <= load_for(ST_RST_LOW);
            lt24_reset_n <= 1'b0;
            lt24_cs_n    <= 1'b1;
            lt24_wr_n    <= 1'b1;
            lt24_rs      <= LT24_RS_CMD;
            lt24_d       <= '0;
            init_done    <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            lt24_reset_n <= reset_n_nxt;
            lt24_cs_n    <= cs_n_nxt;
            lt24_wr_n    <= wr_n_nxt;
            lt24_rs      <= rs_nxt;
            lt24_d       <= d_nxt;
            init_done    <= init_done_nxt;
        end
    end

    // Next state and counter
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RST_LOW:  if (cnt == '0) state_nxt = ST_RST_WAIT;
            ST_RST_WAIT: if (cnt == '0) state_nxt = ST_IDLE;
            ST_IDLE:     if (handshake) state_nxt = ST_SETUP;
            ST_SETUP:    state_nxt = ST_WR_LOW;
            ST_WR_LOW:   if (cnt == '0) state_nxt = ST_WR_HIGH;
            ST_WR_HIGH: begin
                if (cnt == '0) state_nxt = handshake ? ST_SETUP : ST_IDLE;
            end
            default:     state_nxt = ST_RST_LOW;
        endcase
        if (rst_req) state_nxt = ST_RST_LOW;

        // Reload on any state change, and on rst_req so a request during
        // RST_LOW restarts the pulse; otherwise count down and hold at zero.
        if (rst_req || state_nxt != state) begin
            cnt_nxt = load_for(state_nxt);
        end else if (cnt != '0) begin
            cnt_nxt = cnt - CNT_W'(1);
        end else begin
            cnt_nxt = cnt;
        end
    end

    // Pin values for the next clock, decoded from the next state
    always_comb begin
        reset_n_nxt   = (state_nxt != ST_RST_LOW);
        wr_n_nxt      = (state_nxt != ST_WR_LOW);
        cs_n_nxt      = !(state_nxt inside {ST_SETUP, ST_WR_LOW, ST_WR_HIGH});
        init_done_nxt = (state_nxt inside {ST_IDLE, ST_SETUP, ST_WR_LOW, ST_WR_HIGH});
        // Bus only changes on the edge that enters SETUP, where wr_n is high
        // on both sides of the edge.
        rs_nxt        = lt24_rs;
        d_nxt         = lt24_d;
        if (handshake) begin
            rs_nxt = s_rs;
            d_nxt  = s_data;
        end
    end

endmodule

// File: tb/tb_lt24_lcd_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lt24_lcd_write_ctrl
// Directed stimulus with a scoreboard: each accepted word that must reach the
// panel is queued; a negedge monitor pops and compares on every completed
// write strobe (wr_n rising with cs_n low and the panel out of reset).
// ---------------------------------------------------------------------------
module tb_lt24_lcd_write_ctrl;
    import lt24_pkg::*;

    typedef struct packed {
        logic        rs;
        logic [15:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rst_req = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_rs = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_ready, init_done, busy;
    logic        lt24_cs_n, lt24_rs, lt24_wr_n, lt24_rd_n, lt24_reset_n;
    logic [15:0] lt24_d;

    int total = 0;
    int bad   = 0;

    wr_t exp_q[$];
    int  falls[$];
    int  cyc = 0;
    int  low_run = 0;
    int  cs_run = 0;
    int  last_cs_run = 0;
    bit  mon_en = 1'b0;
    logic        prev_wr_n = 1'b1;
    logic [16:0] prev_rsd = '0;

    lt24_lcd_write_ctrl #(
        .RST_LOW_CYCLES (4),
        .RST_WAIT_CYCLES(8),
        .WR_LOW_CYCLES  (2),
        .WR_HIGH_CYCLES (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rst_req     (rst_req),
        .s_valid     (s_valid),
        .s_rs        (s_rs),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .init_done   (init_done),
        .busy        (busy),
        .lt24_cs_n   (lt24_cs_n),
        .lt24_rs     (lt24_rs),
        .lt24_wr_n   (lt24_wr_n),
        .lt24_rd_n   (lt24_rd_n),
        .lt24_d      (lt24_d),
        .lt24_reset_n(lt24_reset_n)
    );

    always #10 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            wr_t e;
            cyc++;
            if (prev_wr_n === 1'b1 && lt24_wr_n === 1'b0) falls.push_back(cyc);
            if (lt24_wr_n === 1'b0) low_run++;
            if (prev_wr_n === 1'b0 && lt24_wr_n === 1'b1) begin
                if (lt24_reset_n === 1'b1 && lt24_cs_n === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_write: got rs=%0b d=%04h expected no write",
                                 lt24_rs, lt24_d);
                    end else begin
                        e = exp_q.pop_front();
                        chk("write_rs", {31'd0, lt24_rs}, {31'd0, e.rs});
                        chk("write_d", {16'd0, lt24_d}, {16'd0, e.d});
                        chk("wr_low_width", low_run, 2);
                    end
                end
                low_run = 0;
            end
            // Bus may only move on an edge where wr_n is high before and after.
            if ({lt24_rs, lt24_d} !== prev_rsd)
                chk("bus_change_vs_wr_n", {30'd0, prev_wr_n, lt24_wr_n}, 32'd3);
            if (lt24_cs_n === 1'b0) begin
                cs_run++;
            end else if (cs_run > 0) begin
                last_cs_run = cs_run;
                cs_run = 0;
            end
            prev_wr_n = lt24_wr_n;
            prev_rsd  = {lt24_rs, lt24_d};
        end
    end

    // Offer one word and wait for its handshake; leaves s_valid asserted.
    task automatic send(input logic rs, input logic [15:0] d, input bit push,
                        output int waits, output logic hs_init);
        bit done = 1'b0;
        s_valid = 1'b1;
        s_rs    = rs;
        s_data  = d;
        waits   = 0;
        hs_init = 1'b0;
        while (!done && waits < 100) begin
            @(negedge clk);
            waits++;
            if (s_ready === 1'b1) begin
                done    = 1'b1;
                hs_init = init_done;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no handshake expected one for d=%04h", d);
        end else if (push) begin
            exp_q.push_back('{rs: rs, d: d});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b0 && n < 100);
        chk("idle_reached", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Called just after the edge that put the DUT into RST_LOW (or after
    // async reset release): checks the 4-clock pulse and 8-clock wait.
    task automatic reset_seq_check(input string tag);
        int  lo = 0, hi = 0, n = 0;
        bit  quiet = 1'b1;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (lt24_reset_n === 1'b1 && init_done === 1'b1) break;
            if (lt24_reset_n === 1'b0 && hi == 0) lo++;
            else hi++;
            if (s_ready !== 1'b0 || lt24_cs_n !== 1'b1 || lt24_wr_n !== 1'b1 ||
                init_done !== 1'b0) quiet = 1'b0;
        end
        chk({tag, "_reset_low_len"}, lo, 4);
        chk({tag, "_reset_wait_len"}, hi, 8);
        chk({tag, "_reset_quiet"}, {31'd0, quiet}, 32'd1);
        chk({tag, "_init_done"}, {31'd0, init_done}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1);
    end

    initial begin
        int   w;
        logic hi;
        logic [5:0] cs_v, wr_v;
        bit   stable;

        // Reset state
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_lt24_reset_n", {31'd0, lt24_reset_n}, 32'd0);
        chk("rst_cs_n", {31'd0, lt24_cs_n}, 32'd1);
        chk("rst_wr_n", {31'd0, lt24_wr_n}, 32'd1);
        chk("rst_rs", {31'd0, lt24_rs}, 32'd0);
        chk("rst_d", {16'd0, lt24_d}, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_rd_n", {31'd0, lt24_rd_n}, 32'd1);
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        reset_seq_check("init");

        // Single command word 002C
        send(LT24_RS_CMD, 16'h002C, 1'b1, w, hi);
        s_valid = 1'b0;
        cs_v = '0;
        wr_v = '0;
        stable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cs_v = {cs_v[4:0], lt24_cs_n};
            wr_v = {wr_v[4:0], lt24_wr_n};
            if (i < 5 && (lt24_d !== 16'h002C || lt24_rs !== LT24_RS_CMD)) stable = 1'b0;
        end
        chk("single_cs_pattern", {26'd0, cs_v}, {26'd0, 6'b000001});
        chk("single_wr_pattern", {26'd0, wr_v}, {26'd0, 6'b100111});
        chk("single_bus_stable", {31'd0, stable}, 32'd1);
        chk("single_back_idle", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk("single_cs_run", last_cs_run, 5);

        // Burst of 4 data words
        falls.delete();
        for (int k = 1; k <= 4; k++) begin
            send(LT24_RS_DATA, 16'(k), 1'b1, w, hi);
            if (k > 1) chk($sformatf("burst_accept_gap_%0d", k), w, 5);
        end
        s_valid = 1'b0;
        wait_idle();
        chk("burst_cs_run", last_cs_run, 20);
        chk("burst_pulses", falls.size(), 4);
        for (int k = 1; k < falls.size(); k++)
            chk($sformatf("burst_pulse_spacing_%0d", k), falls[k] - falls[k-1], 5);

        // s_valid offered during RST_WAIT, then during WR_LOW
        rst_req = 1'b1;
        @(posedge clk);
        #1;
        rst_req = 1'b0;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (lt24_reset_n !== 1'b1 && n < 100);
            chk("reached_rst_wait", {31'd0, lt24_reset_n}, 32'd1);
            @(posedge clk);
            #1;
        end
        send(LT24_RS_CMD, 16'h0A5A, 1'b1, w, hi);
        chk("rstwait_accept_after_init", {31'd0, hi}, 32'd1);
        send(LT24_RS_DATA, 16'hBEEF, 1'b1, w, hi);
        chk("wrlow_accept_gap", w, 5);
        s_valid = 1'b0;
        wait_idle();

        // rst_req during WR_LOW aborts the write
        send(LT24_RS_DATA, 16'hDEAD, 1'b0, w, hi);
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_in_wr_low", {31'd0, lt24_wr_n}, 32'd0);
        rst_req = 1'b1;
        @(posedge clk);
        #1;
        rst_req = 1'b0;
        chk("abort_wr_n", {31'd0, lt24_wr_n}, 32'd1);
        chk("abort_cs_n", {31'd0, lt24_cs_n}, 32'd1);
        chk("abort_lt24_reset_n", {31'd0, lt24_reset_n}, 32'd0);
        chk("abort_init_done", {31'd0, init_done}, 32'd0);
        reset_seq_check("rstreq");
        send(LT24_RS_CMD, 16'h0029, 1'b1, w, hi);
        s_valid = 1'b0;
        wait_idle();

        // Async reset during WR_HIGH of a burst
        send(LT24_RS_DATA, 16'h1234, 1'b1, w, hi);
        send(LT24_RS_DATA, 16'h5678, 1'b1, w, hi);
        s_data = 16'h9ABC;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("pre_async_in_wr_high", {30'd0, lt24_cs_n, lt24_wr_n}, 32'd1);
        reset_n = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("async_lt24_reset_n", {31'd0, lt24_reset_n}, 32'd0);
        chk("async_cs_n", {31'd0, lt24_cs_n}, 32'd1);
        chk("async_wr_n", {31'd0, lt24_wr_n}, 32'd1);
        chk("async_rs", {31'd0, lt24_rs}, 32'd0);
        chk("async_d", {16'd0, lt24_d}, 32'd0);
        chk("async_init_done", {31'd0, init_done}, 32'd0);
        chk("async_s_ready", {31'd0, s_ready}, 32'd0);
        chk("async_busy", {31'd0, busy}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        reset_seq_check("async");
        send(LT24_RS_DATA, 16'hC0DE, 1'b1, w, hi);
        s_valid = 1'b0;
        wait_idle();

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
